// File: rtl/binary_mul_pkg.sv
// Shared types and sizing for the 7x7 multiplier and its accumulation stage.
// Optional feature macro: BINARY_MUL_ACC_SAT_EN (saturating accumulation).
package binary_mul_pkg;

  localparam int MUL_P_W   = 14;
  localparam int MUL_N_MAX = 64;
  localparam int MUL_ACC_W = MUL_P_W + $clog2(MUL_N_MAX);
  localparam int MUL_LEN_W = $clog2(MUL_N_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } mul_acc_state_t;

endpackage

// File: rtl/binary_mul_acc_if.sv
// Product-in / result-out bundle for binary_mul_acc.
// Optional feature macro: BINARY_MUL_ACC_SAT_EN (no effect on this file).
interface binary_mul_acc_if #(
  parameter int P_W   = 14,
  parameter int ACC_W = 20,
  parameter int LEN_W = 7
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic [P_W-1:0]   p_in;
  logic             p_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, p_in, p_valid, out_ready,
    input  out_data, out_valid, busy, ovf
  );

  modport slave (
    input  start, len, p_in, p_valid, out_ready,
    output out_data, out_valid, busy, ovf
  );

endinterface

// File: rtl/binary_mul_acc_add.sv
// ACC_W adder with carry-out; saturates instead of wrapping when
// BINARY_MUL_ACC_SAT_EN is defined.
module binary_mul_acc_add #(
  parameter int P_W   = 14,
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [P_W-1:0]   p_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] full;

  assign full    = {1'b0, acc_i} + (ACC_W+1)'(p_i);
  assign carry_o = full[ACC_W];

`ifdef BINARY_MUL_ACC_SAT_EN
  // Once pinned at all-ones every further term carries again, so it stays.
  assign sum_o = carry_o ? '1 : full[ACC_W-1:0];
`else
  assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/binary_mul_acc.sv
// Accumulates len (1..N_MAX) multiplier products into one registered result.
// Optional feature macro: BINARY_MUL_ACC_SAT_EN (saturate on overflow).
module binary_mul_acc
  import binary_mul_pkg::*;
#(
  parameter int P_W   = MUL_P_W,
  parameter int N_MAX = MUL_N_MAX,
  parameter int ACC_W = MUL_ACC_W,
  parameter int LEN_W = MUL_LEN_W
) (
  input logic            clk,
  input logic            rst_n,
  binary_mul_acc_if.slave acc_if
);

  localparam logic [LEN_W-1:0] NMAX_L = LEN_W'(N_MAX);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

  mul_acc_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [LEN_W-1:0] len_clamp;
  logic [ACC_W-1:0] sum;
  logic             carry;

  assign len_clamp = (acc_if.len > NMAX_L) ? NMAX_L : acc_if.len;

  binary_mul_acc_add #(
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .p_i     (acc_if.p_in),
    .sum_o   (sum),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (acc_if.start) begin
          len_d   = len_clamp;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len_clamp == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (acc_if.p_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + ONE_L;
          ovf_d = ovf_q | carry;
          if (cnt_q == len_q - ONE_L) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_if.out_data  = acc_q;
  assign acc_if.out_valid = (state_q == HOLD);
  assign acc_if.busy      = (state_q != IDLE);
  assign acc_if.ovf       = ovf_q;

endmodule

// File: tb/tb_binary_mul_acc.sv
// Bench for binary_mul_acc: a 20-bit and a 16-bit accumulator share one
// stimulus stream and are checked against a plain-arithmetic sum model.
module tb_binary_mul_acc;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  binary_mul_acc_if #(.P_W(14), .ACC_W(20), .LEN_W(7)) if20 ();
  binary_mul_acc_if #(.P_W(14), .ACC_W(16), .LEN_W(7)) if16 ();

  assign if16.start     = if20.start;
  assign if16.len       = if20.len;
  assign if16.p_in      = if20.p_in;
  assign if16.p_valid   = if20.p_valid;
  assign if16.out_ready = if20.out_ready;

  binary_mul_acc #(
    .P_W(14), .N_MAX(64), .ACC_W(20), .LEN_W(7)
  ) u_dut20 (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_if (if20)
  );

  binary_mul_acc #(
    .P_W(14), .N_MAX(64), .ACC_W(16), .LEN_W(7)
  ) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_if (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Final value is the true sum reduced by the overflow policy.
  function automatic void model(input int w, input int unsigned prods[$],
                                output longint data, output bit ov);
    longint total;
    longint lim;
    total = 0;
    foreach (prods[i]) total += longint'(prods[i]);
    lim = (longint'(1) << w);
    ov  = (total >= lim);
`ifdef BINARY_MUL_ACC_SAT_EN
    data = ov ? lim - 1 : total;
`else
    data = total % lim;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid20"}, 32'(if20.out_valid), 0);
    chk({tag, "_busy20"}, 32'(if20.busy), 0);
    chk({tag, "_valid16"}, 32'(if16.out_valid), 0);
    chk({tag, "_busy16"}, 32'(if16.busy), 0);
  endtask

  task automatic chk_result(input string tag, input longint e20,
                            input bit o20, input longint e16, input bit o16);
    chk({tag, "_valid20"}, 32'(if20.out_valid), 1);
    chk({tag, "_data20"}, 32'(if20.out_data), e20[31:0]);
    chk({tag, "_ovf20"}, 32'(if20.ovf), 32'(o20));
    chk({tag, "_valid16"}, 32'(if16.out_valid), 1);
    chk({tag, "_data16"}, 32'(if16.out_data), e16[31:0]);
    chk({tag, "_ovf16"}, 32'(if16.ovf), 32'(o16));
  endtask

  task automatic run_txn(input string tag, input int lenv,
                         input int unsigned prods[$], input int min_stall,
                         input int max_stall, input int ready_wait,
                         input bit poke_start);
    longint e20, e16;
    bit     o20, o16;
    int     s;
    model(20, prods, e20, o20);
    model(16, prods, e16, o16);
    @(posedge clk); #1;
    if20.start = 1'b1;
    if20.len   = 7'(lenv);
    @(posedge clk); #1;
    if20.start = 1'b0;
    if20.len   = 7'($urandom);
    chk({tag, "_busy"}, 32'(if20.busy), 1);
    foreach (prods[i]) begin
      s = int'($urandom_range(max_stall, min_stall));
      repeat (s) begin
        if (poke_start) begin
          if20.start = 1'b1;
          if20.len   = 7'd1;
        end
        @(posedge clk); #1;
        if20.start = 1'b0;
      end
      if20.p_valid = 1'b1;
      if20.p_in    = 14'(prods[i]);
      @(posedge clk); #1;
      if20.p_valid = 1'b0;
      if20.p_in    = 14'($urandom);
    end
    @(negedge clk);
    chk_result(tag, e20, o20, e16, o16);
    repeat (ready_wait) begin
      if20.p_valid = 1'b1;
      @(negedge clk);
      chk_result({tag, "_hold"}, e20, o20, e16, o16);
    end
    if20.p_valid   = 1'b0;
    if20.out_ready = 1'b1;
    @(posedge clk); #1;
    if20.out_ready = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_done"});
  endtask

  initial begin
    int unsigned q[$];
    int          n;
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    if20.start     = 1'b0;
    if20.len       = '0;
    if20.p_in      = '0;
    if20.p_valid   = 1'b0;
    if20.out_ready = 1'b0;

    @(negedge clk);
    chk_idle("reset");
    chk("reset_data20", 32'(if20.out_data), 0);
    chk("reset_ovf20", 32'(if20.ovf), 0);
    chk("reset_data16", 32'(if16.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    q = {100, 200, 300};
    run_txn("basic", 3, q, 0, 0, 0, 1'b0);

    q = {5, 7};
    run_txn("stall", 2, q, 2, 2, 3, 1'b0);

    q = {};
    for (int i = 0; i < 64; i++) q.push_back(16129);
    run_txn("full", 64, q, 0, 0, 0, 1'b0);

    q = {16129, 16129, 16129, 16129, 16129};
    run_txn("ovf", 5, q, 0, 1, 1, 1'b0);

    q = {};
    run_txn("zero", 0, q, 0, 0, 1, 1'b0);

    q = {10, 20, 30};
    run_txn("poke", 3, q, 1, 1, 0, 1'b0);
    run_txn("poke_ign", 3, q, 1, 2, 0, 1'b1);

    q = {};
    for (int i = 0; i < 64; i++) q.push_back($urandom_range(16129, 0));
    run_txn("clamp", 100, q, 0, 0, 0, 1'b0);

    @(posedge clk); #1;
    if20.start = 1'b1;
    if20.len   = 7'd4;
    @(posedge clk); #1;
    if20.start   = 1'b0;
    if20.p_valid = 1'b1;
    if20.p_in    = 14'd16129;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_idle("rstmid");
    chk("rstmid_data20", 32'(if20.out_data), 0);
    chk("rstmid_ovf16", 32'(if16.ovf), 0);
    chk("rstmid_data16", 32'(if16.out_data), 0);
    if20.p_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q = {9};
    run_txn("after_rst", 1, q, 0, 0, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      n = (t % 8 == 7) ? 0 : int'($urandom_range(64, 1));
      q = {};
      for (int i = 0; i < n; i++) begin
        q.push_back((t % 3 == 0) ? $urandom_range(16129, 15000)
                                 : $urandom_range(16129, 0));
      end
      run_txn("rand", n, q, 0, 2, int'($urandom_range(3, 0)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/binary_mul_acc.md
# binary_mul_acc

Downstream accumulation stage for the 7×7 unsigned array multiplier: consumes the registered 14-bit product stream and sums a programmable number of terms (1–64) into a single dot-product result. Sits directly after the multiplier, whose `en` is driven one cycle ahead of `p_valid` by the operand sequencer. Results leave on a valid/ready handshake, so a stalled consumer holds the accumulator without losing data.

## Interface
- `P_W`, 14, product width; matches the multiplier output.
- `N_MAX`, 64, maximum terms per accumulation.
- `ACC_W`, 20, accumulator width; `P_W + clog2(N_MAX)` gives lossless accumulation.
- `LEN_W`, 7, width of `len`; `clog2(N_MAX)+1`.

Ports:
- `clk` in 1: rising-edge clock, shared with the multiplier.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin an accumulation; sampled only in IDLE.
- `len` in `LEN_W`: term count, latched on `start`; values above `N_MAX` are clamped to `N_MAX`.
- `p_in` in `P_W`: product from the multiplier `P`.
- `p_valid` in 1: `p_in` is a valid term this cycle.
- `out_data` out `ACC_W`: accumulated result.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `busy` out 1: high in ACCUM and HOLD.
- `ovf` out 1: overflow occurred in the current or last result. Cleared on the next accepted `start`.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- **IDLE**
  - On `start=1`, latch `len`, clear the accumulator, clear `ovf`, and set `cnt=0`.
  - Then go to ACCUM. If `len==0`, go straight to HOLD with `out_data=0`.
- **ACCUM**
  - Each cycle with `p_valid=1`: `acc <= acc + zero_ext(p_in)` and `cnt++`.
  - When the accepted term is number `len` (`cnt==len-1`), go to HOLD.
  - Cycles with `p_valid=0` are stall cycles; the accumulator and counter hold.
- **HOLD**
  - `out_valid=1` and `out_data=acc` are held stable.
  - When `out_valid && out_ready`, go to IDLE.
- Outside ACCUM, `p_valid` and `p_in` are ignored.
- Outside IDLE, `start` is ignored; there is no restart mid-accumulation.
- Addition is unsigned, `ACC_W` bits. Carry out of bit `ACC_W-1` sets `ovf`, which stays set until the next `start`. Data behaviour on overflow is set by the configuration below.
- Reset values: state=IDLE, `acc=0`, `cnt=0`, `out_data=0`, `out_valid=0`, `busy=0`, `ovf=0`.

## Timing
- Throughput: one term per cycle, with no bubbles between consecutive `p_valid` cycles.
- Latency: `out_valid` rises on the clock edge that accepts the last term. The result is visible in the cycle after the last `p_valid` cycle.
- Back-to-back operation: `start` may be asserted in the cycle after the output handshake. Minimum spacing is `len`+2 cycles per accumulation when `out_ready` is tied high.
- `out_data` is registered; there is no combinational path from `p_in` to any output.
- Asserting `rst_n` low mid-operation asynchronously returns every output to its reset value; the partial sum is discarded.
- `len=N_MAX` with all products at 16129 gives 1,032,256. This fits `ACC_W=20`, with no `ovf`.

## Configuration
- Macro: `BINARY_MUL_ACC_SAT_EN`.
- **Defined:** on overflow the accumulator saturates at `2^ACC_W-1` and stays there for the remaining terms. `ovf` is set.
- **Undefined:** the accumulator wraps modulo `2^ACC_W`. `ovf` is still set.

## Structure
- Shared package `binary_mul_pkg` holds:
  - the `mul_acc_state_t` enum (IDLE/ACCUM/HOLD);
  - `MUL_P_W=14`;
  - `MUL_N_MAX=64`.
- One sub-module, `binary_mul_acc_add`: the `ACC_W` adder with carry-out and the saturate/wrap select under the macro. The FSM and counter live in the top.

## Test plan
- **Basic sum:** `start`, `len=3`, products 100, 200, 300 on consecutive cycles → `out_valid` in the next cycle, `out_data=600`, `ovf=0`.
- **Stall:** `len=2`, products 5 and 7 with two `p_valid=0` cycles between them, `out_ready=0` for 3 cycles → `out_data=12` held stable, drops on the handshake, state returns to IDLE.
- **Full range:** `len=64`, every product 16129 → `out_data=1032256`, `ovf=0`.
- **Overflow, `ACC_W=16`:** `len=5`, every product 16129.
  - With `BINARY_MUL_ACC_SAT_EN` → `out_data=65535`, `ovf=1`.
  - Without it → `out_data=15109`, `ovf=1`.
- **Zero length and ignored start:** `len=0` → `out_data=0` the next cycle. A `start` pulse during ACCUM is ignored; the sum is unchanged.
- **Reset mid-run:** drop `rst_n` after 2 of 4 terms → all outputs 0 and state IDLE immediately. A new `len=1`, product 9 → `out_data=9`.
